// File: rtl/nested_counter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nested_counter
//
// Cascaded multi-digit counter for OFDM framing (e.g. sample -> subcarrier ->
// symbol). Each of the STAGES digits has its own runtime modulus, the chain
// can count up or down, and an optional saturate mode stops the chain at its
// final terminal value instead of rolling over.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset (cnt = 0, done = 0)
//   En_cnt     - count enable, advances stage 0 by one step
//   clr        - synchronous clear to the start value of the current dir
//   load       - synchronous parallel load of load_val
//   load_val   - load value, stage i in bits [i*W +: W]
//   dir        - 0 = count up, 1 = count down
//   sat        - 0 = wrap mode, 1 = stop at the chain's final terminal
//   mod_vec    - per-stage modulus N_i (0 means 2^W)
//   cnt        - registered counter values, stage i in bits [i*W +: W]
//   stage_last - stage i is at its terminal value
//   stage_wrap - stage i wraps on this edge
//   all_last   - whole chain rolls over on this edge
//   done       - sticky flag, set when the chain saturates with sat = 1
// ---------------------------------------------------------------------------
module nested_counter #(
    parameter int STAGES = 3,
    parameter int W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  En_cnt,
    input  logic                  clr,
    input  logic                  load,
    input  logic [STAGES*W-1:0]   load_val,
    input  logic                  dir,
    input  logic                  sat,
    input  logic [STAGES*W-1:0]   mod_vec,
    output logic [STAGES*W-1:0]   cnt,
    output logic [STAGES-1:0]     stage_last,
    output logic [STAGES-1:0]     stage_wrap,
    output logic                  all_last,
    output logic                  done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [STAGES-1:0][W-1:0] r_cnt;
    logic                     r_done;

    logic [STAGES-1:0][W-1:0] w_nextCnt;
    logic [STAGES-1:0][W-1:0] w_top;
    logic [STAGES-1:0]        w_last;
    logic [STAGES-1:0]        w_adv;
    logic [STAGES-1:0]        w_wrap;
    logic                     w_nextDone;
    logic                     w_halt;
    logic                     w_run;
    logic                     w_final;
    logic                     w_ctl;

    // Terminal detection and carry chain. w_top is N_i-1 in W bits, so a
    // modulus of 0 naturally yields the full 2^W-1 range. Up-count uses >=
    // so a value left out of range by shrinking the modulus counts as
    // terminal. The carry ripples through w_run: a stage advances only when
    // the enable reaches it through every lower terminal stage.
    always_comb begin
        w_top   = '0;
        w_last  = '0;
        w_adv   = '0;
        w_wrap  = '0;
        w_halt  = sat & r_done;
        w_ctl   = clr | load;
        w_run   = 1'b0;
        w_final = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_top[i]  = mod_vec[i*W +: W] - ONE;
            w_last[i] = dir ? (r_cnt[i] == '0) : (r_cnt[i] >= w_top[i]);
        end
        w_run = En_cnt & ~w_halt;
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i]  = w_run;
            // Wrap flags are suppressed when clr/load override the count.
            w_wrap[i] = w_run & w_last[i] & ~w_ctl;
            w_run     = w_run & w_last[i];
        end
        // Enabled edge with every stage terminal: the chain's final terminal.
        w_final = w_run;
    end

    // Next-state selection: clr beats load beats counting. In saturate mode
    // the final-terminal edge holds cnt and raises done instead of wrapping.
    always_comb begin
        w_nextCnt  = r_cnt;
        w_nextDone = r_done;
        if (clr) begin
            for (int i = 0; i < STAGES; i++) begin
                w_nextCnt[i] = dir ? w_top[i] : '0;
            end
            w_nextDone = 1'b0;
        end else if (load) begin
            w_nextCnt  = load_val;
            w_nextDone = 1'b0;
        end else if (sat & w_final) begin
            w_nextDone = 1'b1;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    if (w_last[i]) begin
                        w_nextCnt[i] = dir ? w_top[i] : '0;
                    end else if (!dir) begin
                        w_nextCnt[i] = r_cnt[i] + ONE;
                    end else if (r_cnt[i] > w_top[i]) begin
                        // Out-of-range down-count snaps to the new top value.
                        w_nextCnt[i] = w_top[i];
                    end else begin
                        w_nextCnt[i] = r_cnt[i] - ONE;
                    end
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_nextCnt;
            r_done <= w_nextDone;
        end
    end

    assign cnt        = r_cnt;
    assign done       = r_done;
    assign stage_last = w_last;
    assign stage_wrap = w_wrap;
    assign all_last   = w_wrap[STAGES-1];

endmodule
